cosim_ep_arbiter: RTL
=====================

COSIM_EP_ARBITER -- requirements
Module: cosim_ep_arbiter

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 4, number of requester channels sharing one cosim endpoint (legal range 2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, payload bits per message.
REQ-003 SHALL have localparam ID_WIDTH = $clog2(NUM_CHANNELS); the endpoint message width is ID_WIDTH+DATA_WIDTH, with the ID in the MSBs.
REQ-004 SHALL have clk  input  1  sole clock, all logic posedge.
REQ-005 SHALL have rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have ReqValid  input  NUM_CHANNELS  per-channel send request.
REQ-007 SHALL have ReqReady  output  NUM_CHANNELS  per-channel send accept.
REQ-008 SHALL have ReqData  input  NUM_CHANNELS*DATA_WIDTH  channel i payload at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have EpInValid / EpInReady / EpInData  output/input/output  1/1/ID_WIDTH+DATA_WIDTH  stream to endpoint DataIn.
REQ-010 SHALL have EpOutValid / EpOutReady / EpOutData  input/output/input  1/1/ID_WIDTH+DATA_WIDTH  stream from endpoint DataOut.
REQ-011 SHALL have RspValid  output  NUM_CHANNELS  one-hot response valid.
REQ-012 SHALL have RspReady  input  NUM_CHANNELS  per-channel response accept.
REQ-013 SHALL have RspData  output  DATA_WIDTH  response payload, shared by all channels.
REQ-014 SHALL have BadId  output  1  sticky flag: a response carried an ID >= NUM_CHANNELS.

Function
REQ-015 Send side SHALL hold one output register (EpInValid, EpInData). It can load when EpInValid=0 or EpInReady=1.
REQ-016 When it can load, the arbiter SHALL grant exactly one valid channel in round-robin order, starting at the channel after the last grant. ReqReady SHALL be high only for that channel, combinationally.
REQ-017 On a grant, EpInData SHALL become {ID, ReqData[i]} on the next edge: 1-cycle latency, full throughput.
REQ-018 EpInData SHALL stay stable while EpInValid=1 and EpInReady=0.
REQ-019 The round-robin pointer SHALL update only on a grant. It wraps from NUM_CHANNELS-1 to 0.
REQ-020 Receive side SHALL hold one response register (RspValid, RspData). EpOutReady = (RspValid==0) or (RspValid & RspReady)!=0.
REQ-021 On an EpOutValid and EpOutReady transfer with ID < NUM_CHANNELS, the block SHALL set RspValid to onehot(ID) and RspData to the payload on the next edge.
REQ-022 On a transfer with ID >= NUM_CHANNELS, the block SHALL drop the message, clear RspValid, and set BadId. Only reset clears BadId.
REQ-023 If a response pop and a new arrival happen in the same cycle, the new message SHALL be loaded with no bubble.
REQ-024 The send and receive paths SHALL be fully independent; a stall on one SHALL NOT affect the other.

Reset
REQ-025 While rst=1, EpInValid, RspValid, BadId and ReqReady SHALL be 0 and EpOutReady SHALL be 0. The RR pointer SHALL reset to channel 0, so channel 0 has first priority.
REQ-026 A reset mid-transfer SHALL discard the held message, with no replay after reset.

Configuration
REQ-027 With COSIM_EP_ARB_STATS_EN defined, the block SHALL add output GrantCount (NUM_CHANNELS*16): per-channel saturating 16-bit send-grant counters, cleared by rst.
REQ-028 Without COSIM_EP_ARB_STATS_EN, the port and its counters SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-029 Package cosim_ep_arb_pkg SHALL hold the ID-width function, the message struct typedef {id, data}, and the stats counter width constant.
REQ-030 Sub-module cosim_rr_arbiter SHALL implement the parameterized round-robin grant (req, advance, grant one-hot) and is the only sub-module.

Verification
REQ-031 All four ReqValid=1 continuously, EpInReady=1: the bench SHALL see EpInData IDs 0,1,2,3,0,... one per cycle.
REQ-032 Channel 2 valid with EpInReady=0 for 5 cycles: the bench SHALL see EpInValid=1 and data stable, one message, and ReqReady[2]=0 after the first grant.
REQ-033 EpOutData={ID=3, 0xDEADBEEF}: the bench SHALL see RspValid=4'b1000 and RspData=0xDEADBEEF on the next cycle.
REQ-034 Response held with RspReady=0 and a second message pending: the bench SHALL see EpOutReady=0 until the pop, then back-to-back delivery.
REQ-035 NUM_CHANNELS=3 with a received ID=3: the bench SHALL see the message dropped, BadId=1 and staying 1, and RspValid=0.
REQ-036 rst asserted while EpInValid=1: the bench SHALL see EpInValid=0 next cycle, and the first grant after reset goes to the lowest valid channel.

Source files
------------

// File: rtl/cosim_ep_arb_pkg.sv
// Shared types and helpers for the cosim endpoint arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cosim_ep_arb_pkg;

    // Width of each per-channel send-grant counter in the stats build.
    localparam int STATS_CNT_W = 16;

    // Default configuration, reused as the top-level parameter defaults.
    localparam int DEF_NUM_CHANNELS = 4;
    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_ID_WIDTH     = $clog2(DEF_NUM_CHANNELS);

    // Number of ID bits needed to name every channel; never less than one bit.
    function automatic int id_width(input int num_channels);
        return (num_channels < 2) ? 1 : $clog2(num_channels);
    endfunction

    // Endpoint message layout at the default configuration: ID in the MSBs.
    // The top declares the same {id, data} shape sized from its own parameters.
    typedef struct packed {
        logic [DEF_ID_WIDTH-1:0]   id;
        logic [DEF_DATA_WIDTH-1:0] data;
    } ep_msg_t;

endpackage

// File: rtl/cosim_rr_arbiter.sv
// Round-robin grant over N requesters; the search starts at the channel after the last grant.
// Latency: grant is combinational from req_i; the pointer moves on the edge after a taken grant.
// Backpressure: the pointer holds unless advance_i is high and some request is present.
module cosim_rr_arbiter
    import cosim_ep_arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = id_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req_i,
    input  logic          advance_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grant_idx_o,
    output logic          grant_any_o
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;

    // Scan channels from the pointer upwards, wrapping, and pick the first requester.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        grant_any_o = 1'b0;
        for (int off = 0; off < N; off++) begin
            int            c;
            logic [IW-1:0] cidx;
            c = int'(ptr_q) + off;
            if (c >= N) begin
                c = c - N;
            end
            cidx = IW'(c);
            if (!grant_any_o && req_i[cidx]) begin
                grant_any_o    = 1'b1;
                grant_idx_o    = cidx;
                grant_o[cidx]  = 1'b1;
            end
        end
    end

    // Next priority is the channel after the one just granted, wrapping at N-1.
    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && grant_any_o) begin
            ptr_d = (grant_idx_o == IW'(N - 1)) ? '0 : grant_idx_o + 1'b1;
        end
    end

    // Pointer register; channel 0 has first priority out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/cosim_ep_arbiter.sv
// Shares one cosim endpoint between NUM_CHANNELS requesters; routes responses back by ID.
// Latency: 1 cycle request->EpIn and EpOut->Rsp, full throughput on both paths.
// Backpressure: EpInReady stalls the send register, RspReady stalls EpOutReady; paths independent.
// Optional: define COSIM_EP_ARB_STATS_EN to add per-channel saturating GrantCount counters.
module cosim_ep_arbiter
    import cosim_ep_arb_pkg::*;
#(
    parameter  int NUM_CHANNELS = DEF_NUM_CHANNELS,
    parameter  int DATA_WIDTH   = DEF_DATA_WIDTH,
    localparam int ID_WIDTH     = id_width(NUM_CHANNELS),
    localparam int MSG_WIDTH    = ID_WIDTH + DATA_WIDTH
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_CHANNELS-1:0]            ReqValid,
    output logic [NUM_CHANNELS-1:0]            ReqReady,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] ReqData,
    output logic                               EpInValid,
    input  logic                               EpInReady,
    output logic [MSG_WIDTH-1:0]               EpInData,
    input  logic                               EpOutValid,
    output logic                               EpOutReady,
    input  logic [MSG_WIDTH-1:0]               EpOutData,
    output logic [NUM_CHANNELS-1:0]            RspValid,
    input  logic [NUM_CHANNELS-1:0]            RspReady,
    output logic [DATA_WIDTH-1:0]              RspData,
    output logic                               BadId
`ifdef COSIM_EP_ARB_STATS_EN
    ,
    output logic [NUM_CHANNELS*STATS_CNT_W-1:0] GrantCount
`endif
);

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [DATA_WIDTH-1:0] data;
    } msg_t;

    // ---------------- send path ----------------
    logic                    can_load;
    logic [NUM_CHANNELS-1:0] grant;
    logic [ID_WIDTH-1:0]     grant_idx;
    logic                    grant_any;
    logic                    advance;

    logic                    in_vld_q;
    logic                    in_vld_d;
    msg_t                    in_dat_q;
    msg_t                    in_dat_d;

    // The output register may take a new message when empty or being drained.
    assign can_load = !rst && (!in_vld_q || EpInReady);
    assign advance  = can_load && grant_any;
    assign ReqReady = can_load ? grant : '0;

    cosim_rr_arbiter #(
        .N (NUM_CHANNELS)
    ) u_rr (
        .clk         (clk),
        .rst         (rst),
        .req_i       (ReqValid),
        .advance_i   (can_load),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .grant_any_o (grant_any)
    );

    // Load the granted channel's payload tagged with its ID; otherwise drain on accept.
    always_comb begin
        in_vld_d = in_vld_q;
        in_dat_d = in_dat_q;
        if (advance) begin
            in_vld_d      = 1'b1;
            in_dat_d.id   = grant_idx;
            in_dat_d.data = ReqData[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        end else if (EpInReady) begin
            in_vld_d = 1'b0;
        end
    end

    // Send register; reset discards any held message so nothing is replayed.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_vld_q <= 1'b0;
            in_dat_q <= '0;
        end else begin
            in_vld_q <= in_vld_d;
            in_dat_q <= in_dat_d;
        end
    end

    assign EpInValid = in_vld_q;
    assign EpInData  = in_dat_q;

    // ---------------- receive path ----------------
    msg_t                    out_msg;
    logic                    id_ok;
    logic                    rsp_pop;
    logic                    out_xfer;

    logic [NUM_CHANNELS-1:0] rsp_vld_q;
    logic [NUM_CHANNELS-1:0] rsp_vld_d;
    logic [DATA_WIDTH-1:0]   rsp_dat_q;
    logic [DATA_WIDTH-1:0]   rsp_dat_d;
    logic                    bad_q;
    logic                    bad_d;

    assign out_msg    = EpOutData;
    assign id_ok      = int'(out_msg.id) < NUM_CHANNELS;
    assign rsp_pop    = |(rsp_vld_q & RspReady);
    // Accept while empty or while the held response leaves this cycle, so no bubble.
    assign EpOutReady = !rst && ((rsp_vld_q == '0) || rsp_pop);
    assign out_xfer   = EpOutValid && EpOutReady;

    // Route a legal ID to its one-hot valid; drop an illegal one and flag it.
    always_comb begin
        rsp_vld_d = rsp_vld_q;
        rsp_dat_d = rsp_dat_q;
        bad_d     = bad_q;
        if (out_xfer) begin
            if (id_ok) begin
                rsp_vld_d = NUM_CHANNELS'(1) << out_msg.id;
                rsp_dat_d = out_msg.data;
            end else begin
                rsp_vld_d = '0;
                bad_d     = 1'b1;
            end
        end else if (rsp_pop) begin
            rsp_vld_d = '0;
        end
    end

    // Response register and sticky bad-ID flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_vld_q <= '0;
            rsp_dat_q <= '0;
            bad_q     <= 1'b0;
        end else begin
            rsp_vld_q <= rsp_vld_d;
            rsp_dat_q <= rsp_dat_d;
            bad_q     <= bad_d;
        end
    end

    assign RspValid = rsp_vld_q;
    assign RspData  = rsp_dat_q;
    assign BadId    = bad_q;

`ifdef COSIM_EP_ARB_STATS_EN
    // ---------------- grant statistics ----------------
    logic [STATS_CNT_W-1:0] cnt_q [NUM_CHANNELS];

    // Count taken grants per channel, holding at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (rst) begin
                cnt_q[i] <= '0;
            end else if (advance && grant[i] && (cnt_q[i] != '1)) begin
                cnt_q[i] <= cnt_q[i] + 1'b1;
            end
        end
    end

    // Flatten the counters onto the output bus, channel i at slice i.
    always_comb begin
        GrantCount = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            GrantCount[i*STATS_CNT_W +: STATS_CNT_W] = cnt_q[i];
        end
    end
`endif

endmodule
